// File: rtl/recovery_lockin_controller.sv
// Clock-recovery lock-in sequencer: times primary events, qualifies a candidate rate, publishes lock.
// Optional feature macro RECOVERY_LOCKIN_TRACKING_EN: while locked, every clean event reloads the rate.

package clks_alot_p;
  parameter int unsigned RATE_COUNTER_WIDTH = 8;
endpackage

module recovery_lockin_controller #(
  parameter int unsigned LOCKIN_COUNT_WIDTH    = 4,
  parameter int unsigned VIOLATION_COUNT_WIDTH = 4
) (
  input  logic                                      clk_i,
  input  logic                                      rst_n_i,
  input  logic                                      enable_i,
  input  logic                                      clear_i,
  input  logic                                      primary_event_i,
  input  logic                                      positive_drift_violation_i,
  input  logic                                      negative_drift_violation_i,
  input  logic [LOCKIN_COUNT_WIDTH-1:0]             lockin_count_i,
  input  logic [VIOLATION_COUNT_WIDTH-1:0]          violation_limit_i,
  output logic [clks_alot_p::RATE_COUNTER_WIDTH-1:0] pending_rate_o,
  output logic [clks_alot_p::RATE_COUNTER_WIDTH-1:0] validated_rate_o,
  output logic                                      rate_locked_in_o,
  output logic                                      rate_update_o,
  output logic                                      lock_lost_o,
  output logic [1:0]                                state_o
);

  localparam int unsigned RW = clks_alot_p::RATE_COUNTER_WIDTH;
  localparam int unsigned LW = LOCKIN_COUNT_WIDTH;
  localparam int unsigned VW = VIOLATION_COUNT_WIDTH;

  typedef enum logic [2:0] {
    StIdle,
    StAcquire,
    StSeed,
    StMeasure,
    StLocked
  } state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] rate_q, rate_d;
  logic [RW-1:0] valid_q, valid_d;
  logic [LW-1:0] match_q, match_d;
  logic [VW-1:0] viol_cnt_q, viol_cnt_d;
  logic          locked_q, locked_d;
  logic          update_q, update_d;
  logic          lost_q, lost_d;

  logic          viol;
  logic          rate_sat;
  logic [LW:0]   match_inc;
  logic [LW:0]   lockin_eff;
  logic [VW:0]   viol_inc;
  logic [VW:0]   limit_eff;

  assign viol      = primary_event_i & (positive_drift_violation_i | negative_drift_violation_i);
  assign rate_sat  = &rate_q;
  // One extra bit so a full-scale threshold cannot be missed by wrap-around.
  assign match_inc = {1'b0, match_q} + (LW + 1)'(1);
  assign viol_inc  = {1'b0, viol_cnt_q} + (VW + 1)'(1);
  assign lockin_eff = (lockin_count_i == '0) ? (LW + 1)'(1) : {1'b0, lockin_count_i};
  assign limit_eff  = (violation_limit_i == '0) ? (VW + 1)'(1) : {1'b0, violation_limit_i};

  // Rate counter: restarts at 1 on each event, saturates instead of wrapping.
  always_comb begin
    rate_d = rate_q;
    if (!enable_i || clear_i || (state_q == StIdle)) begin
      rate_d = '0;
    end else if (primary_event_i) begin
      rate_d = RW'(1);
    end else if (!rate_sat) begin
      rate_d = rate_q + RW'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    match_d    = match_q;
    viol_cnt_d = viol_cnt_q;
    valid_d    = valid_q;
    locked_d   = locked_q;
    update_d   = 1'b0;
    lost_d     = 1'b0;

    if (!enable_i) begin
      state_d    = StIdle;
      match_d    = '0;
      viol_cnt_d = '0;
      valid_d    = '0;
      locked_d   = 1'b0;
    end else if (clear_i) begin
      state_d    = StIdle;
      match_d    = '0;
      viol_cnt_d = '0;
      valid_d    = '0;
      locked_d   = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StAcquire;
        end

        // The first event has no reference edge, so its count is thrown away.
        StAcquire: begin
          if (primary_event_i) begin
            state_d = StSeed;
          end
        end

        StSeed: begin
          if (primary_event_i) begin
            valid_d  = rate_q;
            update_d = 1'b1;
            match_d  = '0;
            state_d  = StMeasure;
          end
        end

        StMeasure: begin
          if (primary_event_i) begin
            if (viol) begin
              valid_d  = rate_q;
              update_d = 1'b1;
              match_d  = '0;
            end else if (match_inc >= lockin_eff) begin
              state_d    = StLocked;
              locked_d   = 1'b1;
              match_d    = '0;
              viol_cnt_d = '0;
            end else begin
              match_d = match_inc[LW-1:0];
            end
          end else if (rate_sat) begin
            state_d    = StAcquire;
            match_d    = '0;
            viol_cnt_d = '0;
          end
        end

        StLocked: begin
          if (primary_event_i) begin
            if (viol) begin
              if (viol_inc >= limit_eff) begin
                lost_d     = 1'b1;
                locked_d   = 1'b0;
                viol_cnt_d = '0;
                state_d    = StSeed;
              end else begin
                viol_cnt_d = viol_inc[VW-1:0];
              end
            end else begin
              viol_cnt_d = '0;
`ifdef RECOVERY_LOCKIN_TRACKING_EN
              valid_d  = rate_q;
              update_d = 1'b1;
`else
              valid_d  = valid_q;
`endif
            end
          end else if (rate_sat) begin
            lost_d     = 1'b1;
            locked_d   = 1'b0;
            match_d    = '0;
            viol_cnt_d = '0;
            state_d    = StAcquire;
          end
        end

        default: begin
          state_d    = StIdle;
          match_d    = '0;
          viol_cnt_d = '0;
          locked_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= StIdle;
      rate_q     <= '0;
      valid_q    <= '0;
      match_q    <= '0;
      viol_cnt_q <= '0;
      locked_q   <= 1'b0;
      update_q   <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rate_q     <= rate_d;
      valid_q    <= valid_d;
      match_q    <= match_d;
      viol_cnt_q <= viol_cnt_d;
      locked_q   <= locked_d;
      update_q   <= update_d;
      lost_q     <= lost_d;
    end
  end

  // MEASURE and LOCKED share a debug code; rate_locked_in_o tells them apart.
  always_comb begin
    state_o = 2'd0;
    case (state_q)
      StAcquire:           state_o = 2'd1;
      StSeed:              state_o = 2'd2;
      StMeasure, StLocked: state_o = 2'd3;
      default:             state_o = 2'd0;
    endcase
  end

  assign pending_rate_o   = rate_q;
  assign validated_rate_o = valid_q;
  assign rate_locked_in_o = locked_q;
  assign rate_update_o    = update_q;
  assign lock_lost_o      = lost_q;

endmodule

// File: tb/tb_recovery_lockin_controller.sv
// Scoreboard bench for recovery_lockin_controller: stimulus queues expected pulses,
// a negedge monitor pops and compares them as the DUT raises them.
module tb_recovery_lockin_controller;

  localparam int RW    = clks_alot_p::RATE_COUNTER_WIDTH;
  localparam int KUpd  = 0;
  localparam int KLock = 1;
  localparam int KLost = 2;

  typedef struct {
    int kind;
    int value;
  } exp_t;

  exp_t sb[$];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          clear = 1'b0;
  logic          pev = 1'b0;
  logic          pviol = 1'b0;
  logic          nviol = 1'b0;
  logic [3:0]    lockin = 4'd3;
  logic [3:0]    limit = 4'd2;
  logic [RW-1:0] pending;
  logic [RW-1:0] validated;
  logic          locked;
  logic          upd;
  logic          lost;
  logic [1:0]    state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  recovery_lockin_controller dut (
    .clk_i                      (clk),
    .rst_n_i                    (rst_n),
    .enable_i                   (enable),
    .clear_i                    (clear),
    .primary_event_i            (pev),
    .positive_drift_violation_i (pviol),
    .negative_drift_violation_i (nviol),
    .lockin_count_i             (lockin),
    .violation_limit_i          (limit),
    .pending_rate_o             (pending),
    .validated_rate_o           (validated),
    .rate_locked_in_o           (locked),
    .rate_update_o              (upd),
    .lock_lost_o                (lost),
    .state_o                    (state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  task automatic push_exp(input int kind, input int value);
    sb.push_back('{kind, value});
  endtask

  task automatic observe(input int kind);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_pulse: got kind %0d expected none", kind);
    end else begin
      e = sb.pop_front();
      check("sb_kind", kind, e.kind);
      if (kind == KLost) check("sb_lost_state", state, e.value);
      else               check("sb_validated", validated, e.value);
    end
  endtask

  // Monitor: observed lock rise, loss pulse and update pulse, in that order.
  initial begin
    logic prev_locked;
    prev_locked = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (locked && !prev_locked) observe(KLock);
        if (lost) observe(KLost);
        if (upd) observe(KUpd);
      end
      prev_locked = locked;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Event captured exactly `period` cycles after the previous capture edge.
  task automatic send(input int period, input logic pv, input logic nv, input int exp_pend);
    repeat (period - 1) tick();
    pev   = 1'b1;
    pviol = pv;
    nviol = nv;
    if (exp_pend >= 0) check("pending_at_event", pending, exp_pend);
    tick();
    pev   = 1'b0;
    pviol = 1'b0;
    nviol = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    // Reset values
    #12;
    check("rst_state", state, 0);
    check("rst_pending", pending, 0);
    check("rst_validated", validated, 0);
    check("rst_locked", locked, 0);
    check("rst_update", upd, 0);
    check("rst_lost", lost, 0);

    @(posedge clk); #1;
    rst_n  = 1'b1;
    enable = 1'b1;
    tick();
    check("idle_to_acquire", state, 1);
    check("acquire_pending_start", pending, 0);

    // Lock: period 10, lockin 3
    send(3, 1'b0, 1'b0, -1);
    check("seed_state", state, 2);
    push_exp(KUpd, 10);
    send(10, 1'b0, 1'b0, 10);
    check("measure_state", state, 3);
    check("measure_unlocked", locked, 0);
    send(10, 1'b0, 1'b0, 10);
    send(10, 1'b0, 1'b0, 10);
    check("prelock_unlocked", locked, 0);
    push_exp(KLock, 10);
    send(10, 1'b0, 1'b0, 10);
    check("lock_asserted", locked, 1);
    check("lock_validated", validated, 10);

    // Tracking: clean event at period 11
`ifdef RECOVERY_LOCKIN_TRACKING_EN
    push_exp(KUpd, 11);
    send(11, 1'b0, 1'b0, 11);
    check("track_validated", validated, 11);
`else
    send(11, 1'b0, 1'b0, 11);
    check("frozen_validated", validated, 10);
`endif

    // Lock loss: limit 2; an intervening clean event resets the count
    send(10, 1'b1, 1'b0, 10);
`ifdef RECOVERY_LOCKIN_TRACKING_EN
    push_exp(KUpd, 10);
`endif
    send(10, 1'b0, 1'b0, 10);
    send(10, 1'b0, 1'b1, 10);
    check("no_loss_locked", locked, 1);
    push_exp(KLost, 2);
    send(10, 1'b1, 1'b1, 10);
    check("loss_state_seed", state, 2);
    check("loss_unlocked", locked, 0);
    check("loss_validated_kept", validated, 10);

    // Re-seed in MEASURE
    push_exp(KUpd, 10);
    send(10, 1'b0, 1'b0, 10);
    send(10, 1'b0, 1'b0, 10);
    push_exp(KUpd, 14);
    send(14, 1'b1, 1'b0, 14);
    check("reseed_validated", validated, 14);
    check("reseed_state", state, 3);
    send(14, 1'b0, 1'b0, 14);
    send(14, 1'b0, 1'b0, 14);
    check("reseed_not_locked", locked, 0);
    push_exp(KLock, 14);
    send(14, 1'b0, 1'b0, 14);
    check("reseed_locked", locked, 1);

    // Timeout from LOCKED
    push_exp(KLost, 1);
    k = 0;
    while (state != 2'd1 && k < 400) begin
      tick();
      k++;
    end
    check("timeout_cycles", k, 255);
    check("timeout_pending_sat", pending, 255);
    check("timeout_unlocked", locked, 0);
    repeat (5) tick();
    check("timeout_pending_held", pending, 255);
    check("timeout_state_held", state, 1);

    // Reacquire; lockin changed to 0 (treated as 1) mid-MEASURE
    send(4, 1'b0, 1'b0, 255);
    push_exp(KUpd, 5);
    send(5, 1'b0, 1'b0, 5);
    send(5, 1'b0, 1'b0, 5);
    lockin = 4'd0;
    push_exp(KLock, 5);
    send(5, 1'b0, 1'b0, 5);
    check("midchange_locked", locked, 1);
    lockin = 4'd3;

    // Clear alone, then clear coincident with the locking event
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_state_idle", state, 0);
    check("clear_pending", pending, 0);
    check("clear_unlocked", locked, 0);
    tick();
    check("clear_then_acquire", state, 1);
    send(2, 1'b0, 1'b0, -1);
    push_exp(KUpd, 6);
    send(6, 1'b0, 1'b0, 6);
    send(6, 1'b0, 1'b0, 6);
    send(6, 1'b0, 1'b0, 6);
    repeat (5) tick();
    pev   = 1'b1;
    clear = 1'b1;
    tick();
    pev   = 1'b0;
    clear = 1'b0;
    check("clrevt_state_idle", state, 0);
    check("clrevt_unlocked", locked, 0);
    check("clrevt_pending", pending, 0);
    tick();
    check("clrevt_acquire", state, 1);
    check("clrevt_still_unlocked", locked, 0);

    // Asynchronous reset mid-MEASURE
    send(3, 1'b0, 1'b0, -1);
    push_exp(KUpd, 7);
    send(7, 1'b0, 1'b0, 7);
    send(7, 1'b0, 1'b0, 7);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_state", state, 0);
    check("arst_pending", pending, 0);
    check("arst_validated", validated, 0);
    check("arst_locked", locked, 0);
    check("arst_update", upd, 0);
    check("arst_lost", lost, 0);

    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
